mdio_responder: RTL and testbench
=================================

// Module: mdio_responder
// PURPOSE
// - PHY-side Clause-22 MDIO management slave. It is the responder to the station-side MDIO master and its FSM.
// - Samples MDC/MDIO in the clk domain and decodes read/write frames addressed to PHY_ADDR.
// - Presents a simple register-file port, and drives read data back onto MDIO through a tristate pair.
// - Used as the loopback/sim PHY model and as the management endpoint of an FPGA-hosted PHY.
// PARAMETERS
// - PHY_ADDR      5'h01  PHY address this block answers to; all other addresses are ignored
// - PREAMBLE_LEN  32     consecutive 1-bits required before ST
// - SYNC_STAGES   2      synchroniser depth for mdc_i and mdio_i (minimum 2)
// PORTS
// - clk          in   1   system clock; must run at least 8x faster than MDC
// - reset        in   1   asynchronous, active-high reset
// - mdc_i        in   1   management clock from station (asynchronous to clk)
// - mdio_i       in   1   MDIO pad input
// - mdio_o       out  1   MDIO pad output value
// - mdio_oe      out  1   MDIO pad output enable (1 = drive)
// - reg_adr      out  5   register address of the current frame
// - reg_rd_req   out  1   1-clk pulse: read of reg_adr requested
// - reg_rd_data  in   16  read data; sampled on the clk edge following reg_rd_req
// - reg_wr_en    out  1   1-clk pulse: write reg_wr_data to reg_adr
// - reg_wr_data  out  16  write data, held until next frame
// - busy         out  1   a frame is being decoded (state != PREAMBLE)
// - frame_err    out  1   1-clk pulse on malformed frame (bad ST, bad OP, bad TA on write)
// BEHAVIOUR
// - Reset: all outputs 0; mdio_o=1 with mdio_oe=0 (released); state=PREAMBLE; counters 0.
// - MDC edges: mdc_i and mdio_i pass through SYNC_STAGES flops. Rising edge = sync'd mdc 0->1.
//   - Every bit below is sampled on a detected rising edge. Driven bits update on the same clk.
// - FSM states and transitions:
//   - PREAMBLE: counts 1s, saturating at PREAMBLE_LEN. A 0 with count<PREAMBLE_LEN clears the count.
//     A 0 with count==PREAMBLE_LEN -> ST.
//   - ST: bit must be 1, else frame_err and -> PREAMBLE.
//   - OP: 2 bits. 10=read, 01=write; 00/11 -> frame_err, SKIP.
//   - PHYAD: 5 bits, MSB first. Mismatch with PHY_ADDR -> SKIP (no error, no pulses).
//   - REGAD: 5 bits. On the last bit reg_adr is loaded. On a read, reg_rd_req pulses; rd data is latched 1 clk later.
//   - TA: 2 bits.
//     - Read: after TA bit1 is sampled, set mdio_oe=1, mdio_o=0 for TA bit2.
//     - Write: TA must be 10, else frame_err and SKIP.
//   - DATA_RD: on each rising edge shift the next bit out, MSB first.
//     After the edge where D0 has been sampled, set mdio_oe=0 -> PREAMBLE.
//   - DATA_WR: shift in 16 bits MSB first. After D0, reg_wr_data updates and reg_wr_en pulses 1 clk -> PREAMBLE.
//   - SKIP: count out the remaining bits to 32 post-preamble bits, never driving -> PREAMBLE.
// - Back-to-back frames: the PREAMBLE count restarts at 0 on frame end. A full preamble is required again (see CONFIGURATION).
// - MDC stopping mid-frame: state is held indefinitely; there is no timeout.
// - Reset mid-frame: mdio_oe drops asynchronously in the same instant; no partial write is issued.
// - Read latency: rd_req is issued 3 MDC bits before the first data bit, so reg_rd_data has 1 clk to settle.
// - mdio_oe is never asserted outside TA bit2 and DATA_RD.
// CONFIGURATION
// - MDIO_PREAMBLE_SUPPRESS_EN defined:
//   - After any completed frame addressed to PHY_ADDR, the next frame is accepted with a preamble of >=1 one-bit.
//   - A failed frame (frame_err or SKIP) re-arms the full PREAMBLE_LEN requirement.
// - MDIO_PREAMBLE_SUPPRESS_EN undefined: PREAMBLE_LEN ones are always required.
// STRUCTURE
// - Package mdio_pkg:
//   - MDIO_OP_READ=2'b10, MDIO_OP_WRITE=2'b01, MDIO_ST=2'b01.
//   - Register addresses BMCR=5'h00, BMSR=5'h01, PHYSR=5'h1A, PAGESEL=5'h1F.
//   - Enum typedef mdio_resp_state_t.
// - Sub-module mdio_sync_edge: SYNC_STAGES synchroniser plus rising-edge detect for mdc_i. A plain synchroniser for mdio_i.
// - Shift register, bit counter (6 bits) and FSM stay in this module.
// TESTING
// - Write: preamble, ST, OP=01, PHYAD=PHY_ADDR, REGAD=5'h1F, TA=10, data 0x0D08 -> one reg_wr_en pulse, reg_adr=0x1F, reg_wr_data=0x0D08.
// - Read: frame to REGAD=5'h01 with reg_rd_data=0x796D:
//   - station samples TA2=0, then 0x796D MSB first;
//   - mdio_oe asserts only for those 17 bits; reg_rd_req pulses once.
// - Wrong PHYAD=5'h07 write of 0xFFFF -> no reg_wr_en, no frame_err; mdio_oe stays 0; busy drops after 32 bits.
// - Short preamble (31 ones) then a valid write -> ignored, no reg_wr_en.
//   - With MDIO_PREAMBLE_SUPPRESS_EN: a second write after a good one with 1-bit preamble -> accepted.
// - OP=11 -> frame_err pulse, no bus drive; the next valid read still returns correct data.
// - Assert reset during DATA_RD bit 5 -> mdio_oe=0 immediately; the following valid frame decodes normally.

Source files
------------

// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_pkg
//  Description : Shared constants and types for the Clause-22 MDIO responder.
//                Frame field codes, well-known PHY register addresses and the
//                responder FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdio_pkg;

  // Frame field codes
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_ST       = 2'b01;

  // Well-known register addresses
  localparam logic [4:0] REG_BMCR    = 5'h00;
  localparam logic [4:0] REG_BMSR    = 5'h01;
  localparam logic [4:0] REG_PHYSR   = 5'h1A;
  localparam logic [4:0] REG_PAGESEL = 5'h1F;

  typedef enum logic [3:0] {
    S_PREAMBLE = 4'd0,
    S_ST       = 4'd1,
    S_OP       = 4'd2,
    S_PHYAD    = 4'd3,
    S_REGAD    = 4'd4,
    S_TA       = 4'd5,
    S_DATA_RD  = 4'd6,
    S_DATA_WR  = 4'd7,
    S_SKIP     = 4'd8
  } mdio_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/mdio_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_responder_if
//  Description : Register-file port between the MDIO responder and the PHY
//                register bank.
//                  reg_adr      register address of the current frame
//                  reg_rd_req   1-clk read request pulse
//                  reg_rd_data  read data, sampled the clk after reg_rd_req
//                  reg_wr_en    1-clk write strobe
//                  reg_wr_data  write data, held until the next write
//                master : responder side, slave : register bank side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdio_responder_if;
  logic [4:0]  reg_adr;
  logic        reg_rd_req;
  logic [15:0] reg_rd_data;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;

  modport master (
    output reg_adr, reg_rd_req, reg_wr_en, reg_wr_data,
    input  reg_rd_data
  );

  modport slave (
    input  reg_adr, reg_rd_req, reg_wr_en, reg_wr_data,
    output reg_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/mdio_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_sync_edge
//  Description : Brings MDC and MDIO into the clk domain through matching
//                synchroniser chains and flags MDC rising edges. Both chains
//                share the same depth so the sampled MDIO bit stays aligned
//                with the detected MDC edge.
//    clk        in   system clock
//    reset      in   asynchronous active-high reset
//    mdc_async  in   raw MDC
//    mdio_async in   raw MDIO pad input
//    mdc_rise   out  1-clk pulse on a synchronised MDC 0->1 transition
//    mdio_sync  out  synchronised MDIO
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mdc_async,
  input  logic mdio_async,
  output logic mdc_rise,
  output logic mdio_sync
);

  // A single flop is not a synchroniser; force at least two.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] r_mdc_sync;
  logic [STAGES-1:0] r_mdio_sync;
  logic              r_mdc_prev;

  // Reset to the idle-high level so an MDC that is already high when reset
  // releases does not produce a phantom rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mdc_sync  <= '1;
      r_mdio_sync <= '1;
      r_mdc_prev  <= 1'b1;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[STAGES-2:0], mdc_async};
      r_mdio_sync <= {r_mdio_sync[STAGES-2:0], mdio_async};
      r_mdc_prev  <= r_mdc_sync[STAGES-1];
    end
  end

  assign mdc_rise  = r_mdc_sync[STAGES-1] & ~r_mdc_prev;
  assign mdio_sync = r_mdio_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_responder
//  Description : PHY-side Clause-22 MDIO management slave. Decodes read and
//                write frames addressed to PHY_ADDR, talks to a register bank
//                through mdio_responder_if, and returns read data on MDIO.
//    clk        in   system clock (>= 8x MDC)
//    reset      in   asynchronous active-high reset
//    mdc_i      in   management clock from the station
//    mdio_i     in   MDIO pad input
//    mdio_o     out  MDIO pad output value
//    mdio_oe    out  MDIO pad output enable (1 = drive)
//    busy       out  a frame is being decoded
//    frame_err  out  1-clk pulse on a malformed frame
//    reg_if     master side of the register-file port
//  Build option: define MDIO_PREAMBLE_SUPPRESS_EN to accept a preamble of a
//                single 1-bit after a frame to this PHY completed cleanly.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'h01,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mdc_i,
  input  logic              mdio_i,
  output logic              mdio_o,
  output logic              mdio_oe,
  output logic              busy,
  output logic              frame_err,
  mdio_responder_if.master  reg_if
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic SUPPRESS_EN = 1'b1;
`else
  localparam logic SUPPRESS_EN = 1'b0;
`endif

  localparam int             PRE_W   = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_LEN);

  // Post-preamble bit positions (1-based: the 0 that ends the preamble is 1).
  localparam logic [5:0] POS_OP_END    = 6'd4;
  localparam logic [5:0] POS_PHYAD_END = 6'd9;
  localparam logic [5:0] POS_REGAD_END = 6'd14;
  localparam logic [5:0] POS_TA1       = 6'd15;
  localparam logic [5:0] POS_FRAME_END = 6'd32;

  logic w_mdc_rise;
  logic w_mdio;

  mdio_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .mdc_async  (mdc_i),
    .mdio_async (mdio_i),
    .mdc_rise   (w_mdc_rise),
    .mdio_sync  (w_mdio)
  );

  mdio_resp_state_t r_state;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [5:0]       r_bit_cnt;
  logic [15:0]      r_shift;
  logic             r_op_hi;
  logic             r_ta_hi;
  logic             r_is_read;
  logic             r_armed;
  logic [4:0]       r_reg_adr;
  logic             r_rd_req;
  logic             r_wr_en;
  logic [15:0]      r_wr_data;
  logic             r_frame_err;
  logic             r_mdio_o;
  logic             r_mdio_oe;

  logic [5:0] w_bit_next;
  logic       w_pre_ok;

  assign w_bit_next = r_bit_cnt + 6'd1;
  // r_armed only ever sets when suppression is built in.
  assign w_pre_ok   = (r_pre_cnt == PRE_MAX) || (r_armed && (r_pre_cnt != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_PREAMBLE;
      r_pre_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_op_hi     <= 1'b0;
      r_ta_hi     <= 1'b0;
      r_is_read   <= 1'b0;
      r_armed     <= 1'b0;
      r_reg_adr   <= '0;
      r_rd_req    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
    end else begin
      r_rd_req    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;

      // Read data is captured one clk after the request; the next MDC edge is
      // many clks away so nothing below can collide with this load.
      if (r_rd_req) begin
        r_shift <= reg_if.reg_rd_data;
      end

      if (w_mdc_rise) begin
        case (r_state)
          S_PREAMBLE: begin
            if (w_mdio) begin
              if (r_pre_cnt != PRE_MAX) r_pre_cnt <= r_pre_cnt + 1'b1;
            end else begin
              r_pre_cnt <= '0;
              if (w_pre_ok) begin
                r_state   <= S_ST;
                r_bit_cnt <= 6'd1;
              end
            end
          end

          S_ST: begin
            if ({1'b0, w_mdio} == MDIO_ST) begin
              r_state   <= S_OP;
              r_bit_cnt <= w_bit_next;
            end else begin
              r_frame_err <= 1'b1;
              r_armed     <= 1'b0;
              r_state     <= S_PREAMBLE;
              r_bit_cnt   <= '0;
            end
          end

          S_OP: begin
            r_bit_cnt <= w_bit_next;
            r_op_hi   <= w_mdio;
            if (w_bit_next == POS_OP_END) begin
              if ({r_op_hi, w_mdio} == MDIO_OP_READ) begin
                r_is_read <= 1'b1;
                r_state   <= S_PHYAD;
              end else if ({r_op_hi, w_mdio} == MDIO_OP_WRITE) begin
                r_is_read <= 1'b0;
                r_state   <= S_PHYAD;
              end else begin
                r_frame_err <= 1'b1;
                r_armed     <= 1'b0;
                r_state     <= S_SKIP;
              end
            end
          end

          S_PHYAD: begin
            r_bit_cnt <= w_bit_next;
            r_shift   <= {r_shift[14:0], w_mdio};
            if (w_bit_next == POS_PHYAD_END) begin
              if ({r_shift[3:0], w_mdio} == PHY_ADDR) begin
                r_state <= S_REGAD;
              end else begin
                r_armed <= 1'b0;
                r_state <= S_SKIP;
              end
            end
          end

          S_REGAD: begin
            r_bit_cnt <= w_bit_next;
            r_shift   <= {r_shift[14:0], w_mdio};
            if (w_bit_next == POS_REGAD_END) begin
              r_reg_adr <= {r_shift[3:0], w_mdio};
              r_rd_req  <= r_is_read;
              r_state   <= S_TA;
            end
          end

          S_TA: begin
            r_bit_cnt <= w_bit_next;
            if (w_bit_next == POS_TA1) begin
              r_ta_hi <= w_mdio;
              // Take the bus for the second turnaround bit, driving 0.
              if (r_is_read) begin
                r_mdio_oe <= 1'b1;
                r_mdio_o  <= 1'b0;
              end
            end else if (r_is_read) begin
              r_mdio_o <= r_shift[15];
              r_shift  <= {r_shift[14:0], 1'b0};
              r_state  <= S_DATA_RD;
            end else if ({r_ta_hi, w_mdio} == 2'b10) begin
              r_state <= S_DATA_WR;
            end else begin
              r_frame_err <= 1'b1;
              r_armed     <= 1'b0;
              r_state     <= S_SKIP;
            end
          end

          S_DATA_RD: begin
            if (w_bit_next == POS_FRAME_END) begin
              r_mdio_oe <= 1'b0;
              r_mdio_o  <= 1'b1;
              r_armed   <= SUPPRESS_EN;
              r_state   <= S_PREAMBLE;
              r_bit_cnt <= '0;
            end else begin
              r_mdio_o  <= r_shift[15];
              r_shift   <= {r_shift[14:0], 1'b0};
              r_bit_cnt <= w_bit_next;
            end
          end

          S_DATA_WR: begin
            r_shift <= {r_shift[14:0], w_mdio};
            if (w_bit_next == POS_FRAME_END) begin
              r_wr_data <= {r_shift[14:0], w_mdio};
              r_wr_en   <= 1'b1;
              r_armed   <= SUPPRESS_EN;
              r_state   <= S_PREAMBLE;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= w_bit_next;
            end
          end

          S_SKIP: begin
            if (w_bit_next == POS_FRAME_END) begin
              r_state   <= S_PREAMBLE;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= w_bit_next;
            end
          end

          default: begin
            r_state   <= S_PREAMBLE;
            r_bit_cnt <= '0;
            r_mdio_oe <= 1'b0;
            r_mdio_o  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mdio_o             = r_mdio_o;
  assign mdio_oe            = r_mdio_oe;
  assign busy               = (r_state != S_PREAMBLE);
  assign frame_err          = r_frame_err;
  assign reg_if.reg_adr     = r_reg_adr;
  assign reg_if.reg_rd_req  = r_rd_req;
  assign reg_if.reg_wr_en   = r_wr_en;
  assign reg_if.reg_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_responder
//  Description : Self-checking bench for mdio_responder. A station model
//                clocks Clause-22 frames onto MDIO; a frame-level reference
//                model predicts register-port activity, errors and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_responder;

  localparam logic [4:0] PHY_ADDR = 5'h01;
  localparam int         HALF     = 80;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam bit SUPP = 1'b1;
`else
  localparam bit SUPP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mdc = 1'b0;
  logic mdio_drv = 1'b1;
  logic mdio_line;
  logic mdio_o, mdio_oe, busy, frame_err;
  logic [15:0] regs [32];

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic [4:0]  last_wr_adr = '0;
  logic [15:0] last_wr_data = '0;

  mdio_responder_if bus ();

  mdio_responder #(
    .PHY_ADDR     (PHY_ADDR),
    .PREAMBLE_LEN (32),
    .SYNC_STAGES  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mdc_i     (mdc),
    .mdio_i    (mdio_line),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .busy      (busy),
    .frame_err (frame_err),
    .reg_if    (bus)
  );

  always #5 clk = ~clk;

  // Open-drain style bus: released line idles high.
  assign mdio_line = mdio_oe ? mdio_o : mdio_drv;
  assign bus.reg_rd_data = regs[bus.reg_adr];

  always @(posedge clk) begin
    if (bus.reg_wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_adr  <= bus.reg_adr;
      last_wr_data <= bus.reg_wr_data;
    end
    if (bus.reg_rd_req) rd_cnt <= rd_cnt + 1;
    if (frame_err)      err_cnt <= err_cnt + 1;
  end

  // Station: drives on MDC low, samples on MDC rise. For reads it releases
  // the line from TA onward. oe_err counts bit times where the pad enable
  // disagrees with "driving only for TA2 .. D0 of an accepted read".
  task automatic run_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] regad,
                           input logic [1:0] ta, input logic [15:0] data,
                           input bit exp_drive, input int abort_pos,
                           output logic [15:0] rd, output logic ta2,
                           output int oe_err, output logic busy_end);
    logic [31:0] bits;
    bits = {st, op, phy, regad, ta, data};
    rd = '0; ta2 = 1'b1; oe_err = 0; busy_end = 1'b0;
    for (int i = 0; i < pre_len; i++) begin
      mdio_drv = 1'b1;
      #HALF; mdc = 1'b1;
      if (mdio_oe !== 1'b0) oe_err++;
      #HALF; mdc = 1'b0;
    end
    for (int p = 1; p <= 32; p++) begin
      mdio_drv = (op == 2'b10 && p >= 15) ? 1'b1 : bits[32-p];
      #HALF; mdc = 1'b1;
      if (mdio_oe !== (exp_drive && p >= 16)) oe_err++;
      if (p == 16) ta2 = mdio_line;
      if (p >= 17) rd[32-p] = mdio_line;
      if (p == 32) busy_end = busy;
      #HALF;
      if (p == abort_pos) break;
      mdc = 1'b0;
    end
    if (abort_pos == 0) begin
      mdio_drv = 1'b1;
      #(4*HALF);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({mdio_oe, mdio_o, busy, frame_err} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_pads: got oe/o/busy/err=%b required 0100", {mdio_oe, mdio_o, busy, frame_err});
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if ({bus.reg_rd_req, bus.reg_wr_en, bus.reg_adr, bus.reg_wr_data} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_regport: got rd=%b wr=%b adr=%h wd=%h required all 0",
               bus.reg_rd_req, bus.reg_wr_en, bus.reg_adr, bus.reg_wr_data);
    end
  endtask

  task automatic test_write();
    int w0, e0, oe_err; logic [15:0] rd; logic ta2, be;
    w0 = wr_cnt; e0 = err_cnt;
    run_frame(32, 2'b01, 2'b01, PHY_ADDR, 5'h1F, 2'b10, 16'h0D08, 1'b0, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (wr_cnt - w0 != 1) begin tests_failed++; $display("FAIL write_pulses: got %0d required 1", wr_cnt - w0); end
    tests_run++;
    if (last_wr_adr !== 5'h1F || last_wr_data !== 16'h0D08) begin
      tests_failed++; $display("FAIL write_value: got adr=%h data=%h required 1f/0d08", last_wr_adr, last_wr_data);
    end
    tests_run++;
    if (err_cnt != e0 || oe_err != 0) begin
      tests_failed++; $display("FAIL write_clean: got err=%0d oe_err=%0d required 0/0", err_cnt - e0, oe_err);
    end
  endtask

  task automatic test_read();
    int r0, oe_err; logic [15:0] rd; logic ta2, be;
    r0 = rd_cnt;
    run_frame(32, 2'b01, 2'b10, PHY_ADDR, 5'h01, 2'b11, 16'h0000, 1'b1, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (rd_cnt - r0 != 1) begin tests_failed++; $display("FAIL read_req: got %0d required 1", rd_cnt - r0); end
    tests_run++;
    if (ta2 !== 1'b0 || rd !== 16'h796D) begin
      tests_failed++; $display("FAIL read_data: got ta2=%b data=%h required 0/796d", ta2, rd);
    end
    tests_run++;
    if (oe_err != 0 || mdio_oe !== 1'b0) begin
      tests_failed++; $display("FAIL read_oe_window: got %0d bad bits, oe=%b required 0/0", oe_err, mdio_oe);
    end
  endtask

  task automatic test_wrong_phy();
    int w0, e0, oe_err; logic [15:0] rd; logic ta2, be;
    w0 = wr_cnt; e0 = err_cnt;
    run_frame(32, 2'b01, 2'b01, 5'h07, 5'h00, 2'b10, 16'hFFFF, 1'b0, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (wr_cnt != w0 || err_cnt != e0 || oe_err != 0) begin
      tests_failed++; $display("FAIL wrong_phy_quiet: got wr=%0d err=%0d oe_err=%0d required 0/0/0",
                               wr_cnt - w0, err_cnt - e0, oe_err);
    end
    tests_run++;
    if (be !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL wrong_phy_busy: got busy@bit32=%b after=%b required 1/0", be, busy);
    end
  endtask

  task automatic test_short_preamble();
    int w0, oe_err; logic [15:0] rd; logic ta2, be;
    w0 = wr_cnt;
    run_frame(31, 2'b01, 2'b01, PHY_ADDR, 5'h1F, 2'b10, 16'h1234, 1'b0, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (wr_cnt != w0) begin tests_failed++; $display("FAIL short_preamble: got %0d writes required 0", wr_cnt - w0); end
  endtask

  task automatic test_suppress();
    int w0, oe_err, exp_w; logic [15:0] rd; logic ta2, be;
    run_frame(32, 2'b01, 2'b01, PHY_ADDR, 5'h00, 2'b10, 16'h1140, 1'b0, 0, rd, ta2, oe_err, be);
    w0 = wr_cnt;
    exp_w = SUPP ? 1 : 0;
    run_frame(1, 2'b01, 2'b01, PHY_ADDR, 5'h00, 2'b10, 16'hA5A4, 1'b0, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (wr_cnt - w0 != exp_w) begin
      tests_failed++; $display("FAIL suppress_writes: got %0d required %0d", wr_cnt - w0, exp_w);
    end
    // Flush with a full-preamble frame so later tests start from a known state.
    run_frame(32, 2'b01, 2'b01, 5'h1E, 5'h00, 2'b10, 16'h0000, 1'b0, 0, rd, ta2, oe_err, be);
  endtask

  task automatic test_bad_op();
    int e0, oe_err; logic [15:0] rd; logic ta2, be;
    e0 = err_cnt;
    run_frame(32, 2'b01, 2'b11, PHY_ADDR, 5'h00, 2'b10, 16'h5555, 1'b0, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (err_cnt - e0 != 1 || oe_err != 0) begin
      tests_failed++; $display("FAIL bad_op: got err=%0d oe_err=%0d required 1/0", err_cnt - e0, oe_err);
    end
    run_frame(32, 2'b01, 2'b10, PHY_ADDR, 5'h1A, 2'b11, 16'h0000, 1'b1, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (rd !== regs[5'h1A] || ta2 !== 1'b0 || oe_err != 0) begin
      tests_failed++; $display("FAIL read_after_bad_op: got %h ta2=%b oe_err=%0d required %h/0/0",
                               rd, ta2, oe_err, regs[5'h1A]);
    end
  endtask

  task automatic test_reset_mid_read();
    int w0, e0, oe_err; logic [15:0] rd; logic ta2, be; logic oe_before;
    run_frame(32, 2'b01, 2'b10, PHY_ADDR, 5'h00, 2'b11, 16'h0000, 1'b1, 22, rd, ta2, oe_err, be);
    oe_before = mdio_oe;
    reset = 1'b1;
    #1;
    tests_run++;
    if (oe_before !== 1'b1 || mdio_oe !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_read_oe: got before=%b after=%b required 1/0", oe_before, mdio_oe);
    end
    #50; @(negedge clk); reset = 1'b0;
    mdc = 1'b0; mdio_drv = 1'b1;
    #(4*HALF);
    w0 = wr_cnt; e0 = err_cnt;
    run_frame(32, 2'b01, 2'b01, PHY_ADDR, 5'h05, 2'b10, 16'hBEEF, 1'b0, 0, rd, ta2, oe_err, be);
    tests_run++;
    if (wr_cnt - w0 != 1 || last_wr_adr !== 5'h05 || last_wr_data !== 16'hBEEF || err_cnt != e0) begin
      tests_failed++; $display("FAIL after_reset_write: got n=%0d adr=%h data=%h err=%0d required 1/05/beef/0",
                               wr_cnt - w0, last_wr_adr, last_wr_data, err_cnt - e0);
    end
  endtask

  task automatic test_random();
    bit armed;
    int kind, pre, w0, r0, e0, oe_err, exp_wr, exp_rd, exp_err;
    bit drive, pre_ok;
    logic [1:0] st, op, ta; logic [4:0] phy, regad; logic [15:0] data, rd; logic ta2, be;
    do_reset();
    armed = 1'b0;
    for (int n = 0; n < 24; n++) begin
      kind  = $urandom_range(0, 9);
      st    = (kind == 9) ? 2'b00 : 2'b01;
      op    = (kind < 4) ? 2'b10 : (kind < 8) ? 2'b01 : (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
      phy   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : PHY_ADDR;
      regad = 5'($urandom);
      data  = 16'($urandom);
      ta    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b10;
      pre   = (SUPP && armed) ? int'($urandom_range(1, 32)) : int'($urandom_range(32, 36));
      // Frame-level rules
      pre_ok = (pre >= 32) || (SUPP && armed);
      exp_wr = 0; exp_rd = 0; exp_err = 0; drive = 1'b0;
      if (!pre_ok) begin
      end else if (st != 2'b01 || (op != 2'b10 && op != 2'b01)) begin
        exp_err = 1; armed = 1'b0;
      end else if (phy != PHY_ADDR) begin
        armed = 1'b0;
      end else if (op == 2'b10) begin
        exp_rd = 1; drive = 1'b1; armed = 1'b1;
      end else if (ta != 2'b10) begin
        exp_err = 1; armed = 1'b0;
      end else begin
        exp_wr = 1; armed = 1'b1;
      end
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      run_frame(pre, st, op, phy, regad, ta, data, drive, 0, rd, ta2, oe_err, be);
      tests_run++;
      if (wr_cnt - w0 != exp_wr || rd_cnt - r0 != exp_rd || err_cnt - e0 != exp_err || oe_err != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_events: got wr=%0d rd=%0d err=%0d oe_err=%0d required %0d/%0d/%0d/0",
                 n, wr_cnt - w0, rd_cnt - r0, err_cnt - e0, oe_err, exp_wr, exp_rd, exp_err);
      end
      if (exp_wr == 1) begin
        tests_run++;
        if (last_wr_adr !== regad || last_wr_data !== data) begin
          tests_failed++; $display("FAIL rand%0d_write: got %h/%h required %h/%h", n, last_wr_adr, last_wr_data, regad, data);
        end
      end
      if (exp_rd == 1) begin
        tests_run++;
        if (rd !== regs[regad] || ta2 !== 1'b0 || bus.reg_adr !== regad) begin
          tests_failed++; $display("FAIL rand%0d_read: got %h ta2=%b adr=%h required %h/0/%h",
                                   n, rd, ta2, bus.reg_adr, regs[regad], regad);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
    regs[1] = 16'h796D;
    test_reset();
    test_write();
    test_read();
    test_wrong_phy();
    test_short_preamble();
    test_suppress();
    test_bad_op();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
